// File: rtl/bcd_prescaler_pkg.sv
// Shared types and helpers for the decade prescaler.
// One BCD digit type plus its up/down successor.
package bcd_prescaler_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX  = 4'd9;
  localparam logic [BCD_W-1:0] BCD_ZERO = 4'd0;

  typedef logic [BCD_W-1:0] bcd_t;

  function automatic bcd_t bcd_next(
    input bcd_t d,
    input logic dn
  );
    bcd_t r;
    if (dn)
      r = (d == BCD_ZERO) ? BCD_MAX : d - 4'd1;
    else
      r = (d == BCD_MAX) ? BCD_ZERO : d + 4'd1;
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade stage: holds a digit, steps up or down,
// and flags terminal count for the carry/borrow chain.
module bcd_digit
  import bcd_prescaler_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic step,
  input  logic dir,
  output bcd_t digit,
  output logic wrap
);

  bcd_t r_q;

  // Terminal count only; the caller gates it with step.
  assign wrap  = dir ? (r_q == BCD_ZERO) : (r_q == BCD_MAX);
  assign digit = r_q;

  always_ff @(posedge clk) begin
    if (!reset)
      r_q <= BCD_ZERO;
    else if (clr)
      r_q <= BCD_ZERO;
    else if (step)
      r_q <= bcd_next(r_q, dir);
  end

endmodule

// File: rtl/bcd_prescaler.sv
// Single-clock decade prescaler: DIGITS cascaded BCD stages,
// registered wrap ticks and a 50% square output.
module bcd_prescaler
  import bcd_prescaler_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  dir,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     tick,
  output logic                  out_sq
);

  bcd_t              w_digit [DIGITS];
  logic [DIGITS-1:0] w_step;
  logic [DIGITS-1:0] w_wrap;
  logic [DIGITS-1:0] w_carry;
  bcd_t              w_top_nxt;
  logic [DIGITS-1:0] r_tick;
  logic              r_sq;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
    if (gi == 0) begin : g_lsd
      assign w_step[gi] = en;
    end else begin : g_upper
      assign w_step[gi] = w_carry[gi-1];
    end

    bcd_digit u_dig (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .step  (w_step[gi]),
      .dir   (dir),
      .digit (w_digit[gi]),
      .wrap  (w_wrap[gi])
    );

    assign bcd[4*gi +: 4] = w_digit[gi];
  end

  assign w_carry = w_step & w_wrap;

  // Top digit >= 5 covers exactly half the full range.
  assign w_top_nxt = w_step[DIGITS-1]
                   ? bcd_next(w_digit[DIGITS-1], dir)
                   : w_digit[DIGITS-1];

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      r_tick <= '0;
      r_sq   <= 1'b0;
    end else begin
      r_tick <= w_carry;
      r_sq   <= (w_top_nxt >= 4'd5);
    end
  end

  assign tick   = r_tick;
  assign out_sq = r_sq;

endmodule

// File: tb/tb_bcd_prescaler.sv
// Scoreboard bench for bcd_prescaler (DIGITS=3): an integer
// count model predicts bcd/tick/out_sq one edge ahead.
module tb_bcd_prescaler;

  localparam int D = 3;
  localparam int N = 1000;

  typedef struct packed {
    logic [4*D-1:0] bcd;
    logic [D-1:0]   tick;
    logic           sq;
  } exp_t;

  logic           clk;
  logic           reset;
  logic           en;
  logic           clr;
  logic           dir;
  logic [4*D-1:0] bcd;
  logic [D-1:0]   tick;
  logic           out_sq;

  exp_t q_exp[$];
  int   cnt;
  int   vectors;
  int   miscompares;
  int   sq_hi;
  int   t0_n, t1_n, t2_n;

  bcd_prescaler #(.DIGITS(D)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .clr    (clr),
    .dir    (dir),
    .bcd    (bcd),
    .tick   (tick),
    .out_sq (out_sq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic r, input logic c,
                       input logic e, input logic d);
    exp_t x, o;
    int   m;
    @(negedge clk);
    reset = r; clr = c; en = e; dir = d;
    x.tick = '0;
    if (!r || c) begin
      cnt = 0;
    end else if (e) begin
      m = 1;
      for (int i = 0; i < D; i++) begin
        m = m * 10;
        x.tick[i] = d ? (cnt % m == 0) : (cnt % m == m - 1);
      end
      cnt = d ? (cnt + N - 1) % N : (cnt + 1) % N;
    end
    x.bcd = to_bcd(cnt);
    x.sq  = (!r || c) ? 1'b0 : (cnt >= N / 2);
    q_exp.push_back(x);
    @(posedge clk);
    #1;
    o = q_exp.pop_front();
    vectors++;
    assert ({bcd, tick, out_sq} === o) else begin
      miscompares++;
      $error("FAIL step bcd=%h tick=%b sq=%b expected bcd=%h tick=%b sq=%b",
             bcd, tick, out_sq, o.bcd, o.tick, o.sq);
    end
    if (out_sq === 1'b1) sq_hi++;
    if (tick[0] === 1'b1) t0_n++;
    if (tick[1] === 1'b1) t1_n++;
    if (tick[2] === 1'b1) t2_n++;
  endtask

  initial begin
    vectors = 0; miscompares = 0; cnt = 0;
    reset = 1'b0; clr = 1'b0; en = 1'b0; dir = 1'b0;

    // Reset state
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 1'b0);

    // Full up run: 1000 enabled edges
    sq_hi = 0; t0_n = 0; t1_n = 0; t2_n = 0;
    for (int i = 0; i < N; i++) apply(1'b1, 1'b0, 1'b1, 1'b0);
    check("sq_high_cycles", sq_hi, 500);
    check("tick0_count", t0_n, 100);
    check("tick1_count", t1_n, 10);
    check("tick2_count", t2_n, 1);
    check("wrap_tick2", int'(tick[2]), 1);
    check("wrap_bcd", int'(bcd), 0);

    // Down from reset: 999 with full borrow, then 998
    apply(1'b0, 1'b0, 1'b0, 1'b1);
    apply(1'b1, 1'b0, 1'b1, 1'b1);
    check("down_bcd999", int'(bcd), 'h999);
    check("down_tick", int'(tick), 7);
    apply(1'b1, 1'b0, 1'b1, 1'b1);
    check("down_bcd998", int'(bcd), 'h998);

    // Random en/dir
    for (int i = 0; i < 400; i++)
      apply(1'b1, 1'b0, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0));

    // Direction flip at 010
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) apply(1'b1, 1'b0, 1'b1, 1'b0);
    check("at_010", int'(bcd), 'h010);
    apply(1'b1, 1'b0, 1'b1, 1'b1);
    check("flip_bcd", int'(bcd), 'h009);
    check("flip_tick0", int'(tick[0]), 1);
    apply(1'b1, 1'b0, 1'b1, 1'b0);

    // Clear at 999 with en=1
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 1'b1);
    apply(1'b1, 1'b1, 1'b1, 1'b1);
    check("clr_bcd", int'(bcd), 0);
    check("clr_tick", int'(tick), 0);
    check("clr_sq", int'(out_sq), 0);

    // Reset at 737
    for (int i = 0; i < 737; i++) apply(1'b1, 1'b0, 1'b1, 1'b0);
    check("at_737", int'(bcd), 'h737);
    check("sq_at_737", int'(out_sq), 1);
    apply(1'b0, 1'b0, 1'b1, 1'b0);
    check("rst_bcd", int'(bcd), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_sq", int'(out_sq), 0);

    check("queue_empty", q_exp.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_prescaler.md
# bcd_prescaler

Parametrised, fully synchronous decade prescaler. It replaces ripple-clocked BCD counter chains with a single-clock-domain chain of `DIGITS` decade stages. Each stage produces a one-cycle clock-enable tick instead of a derived clock. It also provides up/down counting, synchronous clear, count enable, and a registered 50 %-duty square output. It sits between the system clock and any logic that needs a ÷10ⁿ rate, for example 1 kHz → 1 Hz with `DIGITS`=3.

## Interface
- `DIGITS`, default 3: number of cascaded decade stages; total divide ratio is 10^`DIGITS`; legal range 1–8.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-low reset (`reset`==0 at a rising edge of `clk` resets the block).
- `en`  in  1: count enable; the count advances by one on each rising edge where `en`=1.
- `clr`  in  1: synchronous clear, active-high.
- `dir`  in  1: 0 = count up, 1 = count down.
- `bcd`  out  4*`DIGITS`: current count, digit i in bits [4i+3:4i]; digit 0 is the least significant.
- `tick`  out  `DIGITS`: `tick[i]` is a one-cycle pulse when stages 0..i wrap together.
- `out_sq`  out  1: square wave at f_en/10^`DIGITS`, 50 % duty.

## Operation
- Priority at each edge: `reset`==0, then `clr`==1, then `en`==1, then hold.
- Reset and clear behave identically:
  - all digits = 0, `tick` = 0, `out_sq` = 0.
- Up count (`dir`=0, `en`=1):
  - digit 0 increments.
  - Digit i increments only when digits 0..i-1 are all 9.
  - A digit at 9 that increments goes to 0 and carries into the next stage.
- Down count (`dir`=1, `en`=1):
  - digit 0 decrements.
  - Digit i decrements only when digits 0..i-1 are all 0.
  - A digit at 0 that decrements goes to 9 and borrows from the next stage.
- Carry and borrow chain is combinational within one cycle; there are no derived clocks.
- `tick[i]` is registered:
  - it is 1 in the cycle after the edge on which stages 0..i carried out (up) or borrowed out (down);
  - otherwise it is 0.
  - `tick[DIGITS-1]` marks full-range wrap: 999→000 up, 000→999 down.
- `out_sq` is registered: 1 iff the next-state top digit is ≥5.
  - Because the full count runs 0..10^`DIGITS`-1, this gives exactly 50 % duty.
- Digits only ever hold values 0–9. Codes 10–15 are unreachable.
- `dir` may change on any cycle. The new direction applies from the next enabled edge, with no glitch on `tick`.
- `en`=0 holds all digits and `out_sq`; `tick` goes to 0.

## Timing
- Latency is 1 cycle from an enabled edge to updated `bcd`, `tick` and `out_sq`. All outputs are registered.
- `tick` pulses are exactly one cycle wide. With `en` held high, `tick[i]` has period 10^(i+1) cycles.
- Reset or clear asserted mid-count takes effect at that edge. Any pending `tick` is suppressed, since `tick`=0 after that edge.
- When `clr` and `en` are both 1, `clr` wins: the count goes to 0 and no tick is produced.
- First up tick after reset: `tick[0]` is high in the cycle after the 10th enabled edge.

## Structure
- Shared package:
  - `BCD_W`=4;
  - `BCD_MAX`=4'd9;
  - `BCD_ZERO`=4'd0;
  - a BCD digit typedef.
- One sub-module, `bcd_digit`: one decade stage.
  - Inputs: `clk`, `reset`, `clr`, `step` (carry/borrow in AND `en`), `dir`.
  - Outputs: digit value and combinational `wrap` (9→0 going up, 0→9 going down).
- Top level: a generate loop of `DIGITS` `bcd_digit` instances, an AND chain for `step`, the `tick` register and the `out_sq` register.

## Test plan
- Count up with `DIGITS`=3, `reset` pulsed low, then `en`=1 for 1000 cycles:
  - `tick[0]` every 10 cycles, `tick[1]` every 100 cycles;
  - `tick[2]` once, in the cycle after the 1000th enabled edge, with `bcd`=000.
- Square output, same run:
  - `out_sq`=0 while the count is 0–499, =1 while it is 500–999;
  - 500 high cycles out of 1000.
- Count down from reset with `dir`=1:
  - first enabled edge gives `bcd`=999 and `tick[2]`=1 on the following cycle;
  - the next edge gives 998.
- Mid-run events:
  - `en` toggled randomly: the count advances only on `en`=1 edges; `tick` never exceeds one cycle wide.
  - `dir` flipped at `bcd`=010 for one edge: `bcd`=009, `tick[0]`=1.
- Clear and reset mid-run:
  - `clr`=1 at `bcd`=999 with `en`=1: the next cycle shows `bcd`=000, `tick`=0, `out_sq`=0.
  - `reset`=0 at `bcd`=737 gives the same result.
